// File: rtl/pix_lift_pkg.sv
// Shared definitions for the single-row 5/3 lifting pixel RAM.
//   - default sample / address widths
//   - sequencer state encoding
//   - symmetric-extension helper for the left/right neighbour indices
package pix_lift_pkg;

    localparam int unsigned W_DATA_DEF = 26;
    localparam int unsigned W_ADDR_DEF = 7;
    // Index width used by the mirror helper; wide enough for any W_ADDR+1 used here.
    localparam int unsigned MIR_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_PRES = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef struct packed {
        logic [MIR_W-1:0] left_idx;
        logic [MIR_W-1:0] right_idx;
    } mirror_t;

    // Neighbour indices of centre c in a row of length n. Only two positions
    // ever fall off the row: the first update centre (left reflects to 1) and
    // the last predict centre (right reflects to n-2).
    function automatic mirror_t mirror_idx(input logic [MIR_W-1:0] c,
                                           input logic [MIR_W-1:0] n,
                                           input logic             pass_sel);
        mirror_t m;
        m.left_idx  = (pass_sel && (c == '0)) ? MIR_W'(1) : c - MIR_W'(1);
        m.right_idx = (!pass_sel && (c == n - MIR_W'(1))) ? n - MIR_W'(2)
                                                           : c + MIR_W'(1);
        return m;
    endfunction

endpackage

// File: rtl/pix_ram3r1w.sv
// Row storage: DEPTH x W_DATA array with three synchronous triple-read ports,
// an always-active synchronous host read port and one write port.
//   clk, rst_n              clock / async active-low reset (read registers only)
//   wr_en, wr_addr, wr_data single write port (source selected by parent)
//   rd_en                   loads the three triple read registers
//   rd_addr_l/c/r           triple read addresses
//   rd_data_l/c/r           triple read data, held while rd_en is low
//   host_addr, host_dout    host read, one-cycle latency
module pix_ram3r1w
    import pix_lift_pkg::*;
#(
    parameter int unsigned W_DATA = W_DATA_DEF,
    parameter int unsigned W_ADDR = W_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              rd_en,
    input  logic [W_ADDR-1:0] rd_addr_l,
    input  logic [W_ADDR-1:0] rd_addr_c,
    input  logic [W_ADDR-1:0] rd_addr_r,
    output logic [W_DATA-1:0] rd_data_l,
    output logic [W_DATA-1:0] rd_data_c,
    output logic [W_DATA-1:0] rd_data_r,
    input  logic [W_ADDR-1:0] host_addr,
    output logic [W_DATA-1:0] host_dout
);

    localparam int unsigned DEPTH = 1 << W_ADDR;

    logic [W_DATA-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Triple read registers: hold their value outside the read cycle so the
    // presented triple stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_l <= '0;
            rd_data_c <= '0;
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_l <= mem[rd_addr_l];
            rd_data_c <= mem[rd_addr_c];
            rd_data_r <= mem[rd_addr_r];
        end
    end

    // Host read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_dout <= '0;
        end else begin
            host_dout <= mem[host_addr];
        end
    end

endmodule

// File: rtl/pix_lift_ram.sv
// Single-row pixel RAM that sequences one 5/3 lifting pass (predict or update),
// presenting mirrored left/centre/right triples to the lifting datapath and
// writing the returned centre back in place.
//   clk, rst_n                        clock / async active-low reset
//   host_we, host_addr, host_din      host write (IDLE only; otherwise dropped + err)
//   host_dout                         host read data, one-cycle latency, always active
//   start, pass_sel, row_len          pass request, sampled on start in IDLE
//   busy, done, err                   status: pass running / final write-back / rejected request
//   tri_valid, tri_ready              triple handshake
//   tri_left, tri_ctr, tri_right      x[c-1], x[c], x[c+1] after mirroring
//   tri_addr                          centre index c
//   wb_valid, wb_data                 returned centre sample
module pix_lift_ram
    import pix_lift_pkg::*;
#(
    parameter int unsigned W_DATA = W_DATA_DEF,
    parameter int unsigned W_ADDR = W_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_we,
    input  logic [W_ADDR-1:0] host_addr,
    input  logic [W_DATA-1:0] host_din,
    output logic [W_DATA-1:0] host_dout,
    input  logic              start,
    input  logic              pass_sel,
    input  logic [W_ADDR:0]   row_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tri_valid,
    input  logic              tri_ready,
    output logic [W_DATA-1:0] tri_left,
    output logic [W_DATA-1:0] tri_ctr,
    output logic [W_DATA-1:0] tri_right,
    output logic [W_ADDR-1:0] tri_addr,
    input  logic              wb_valid,
    input  logic [W_DATA-1:0] wb_data
);

    localparam int unsigned DEPTH = 1 << W_ADDR;

    state_t            state;
    logic [W_ADDR-1:0] c_q;
    logic [W_ADDR:0]   n_q;
    logic              pass_q;

    logic              start_ok;
    logic              last_ctr;
    mirror_t           mir;
    logic [W_ADDR-1:0] addr_l;
    logic [W_ADDR-1:0] addr_r;
    logic              rd_en;
    logic              wr_en;
    logic [W_ADDR-1:0] wr_addr;
    logic [W_DATA-1:0] wr_data;

    // Row length must be even and within 2..DEPTH.
    assign start_ok = !row_len[0]
                   && (row_len >= (W_ADDR+1)'(2))
                   && (row_len <= (W_ADDR+1)'(DEPTH));

    // The current centre is the last one when c+2 reaches the row end.
    assign last_ctr = (({1'b0, c_q} + (W_ADDR+1)'(2)) >= n_q);

    // Mirrored neighbour addresses for the current centre.
    assign mir    = mirror_idx(MIR_W'(c_q), MIR_W'(n_q), pass_q);
    assign addr_l = W_ADDR'(mir.left_idx);
    assign addr_r = W_ADDR'(mir.right_idx);
    assign rd_en  = (state == ST_RD);

    // Write port: host in IDLE, datapath write-back in WB.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = host_addr;
        wr_data = host_din;
        if (state == ST_IDLE && host_we) begin
            wr_en = 1'b1;
        end else if (state == ST_WB && wb_valid) begin
            wr_en   = 1'b1;
            wr_addr = c_q;
            wr_data = wb_data;
        end
    end

    pix_ram3r1w #(
        .W_DATA (W_DATA),
        .W_ADDR (W_ADDR)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_l (addr_l),
        .rd_addr_c (c_q),
        .rd_addr_r (addr_r),
        .rd_data_l (tri_left),
        .rd_data_c (tri_ctr),
        .rd_data_r (tri_right),
        .host_addr (host_addr),
        .host_dout (host_dout)
    );

    // Pass sequencer with registered status / handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            c_q       <= '0;
            n_q       <= '0;
            pass_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tri_valid <= 1'b0;
            tri_addr  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            n_q    <= row_len;
                            pass_q <= pass_sel;
                            c_q    <= pass_sel ? W_ADDR'(0) : W_ADDR'(1);
                            busy   <= 1'b1;
                            state  <= ST_RD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    tri_valid <= 1'b1;
                    tri_addr  <= c_q;
                    state     <= ST_PRES;
                end
                ST_PRES: begin
                    if (tri_ready) begin
                        tri_valid <= 1'b0;
                        state     <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wb_valid) begin
                        c_q <= c_q + W_ADDR'(2);
                        if (last_ctr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Host writes outside IDLE are dropped and flagged.
            if (host_we && (state != ST_IDLE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pix_lift_ram.sv
`timescale 1ns/1ps
module tb_pix_lift_ram;
    import pix_lift_pkg::*;

    localparam int unsigned WD    = W_DATA_DEF;
    localparam int unsigned WA    = W_ADDR_DEF;
    localparam int unsigned DEPTH = 1 << WA;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_we = 1'b0;
    logic [WA-1:0] host_addr = '0;
    logic [WD-1:0] host_din = '0;
    logic [WD-1:0] host_dout;
    logic          start = 1'b0;
    logic          pass_sel = 1'b0;
    logic [WA:0]   row_len = '0;
    logic          busy, done, err, tri_valid;
    logic          tri_ready;
    logic [WD-1:0] tri_left, tri_ctr, tri_right;
    logic [WA-1:0] tri_addr;
    logic          wb_valid;
    logic [WD-1:0] wb_data;

    // Datapath model drives dp_*; directed tests drive man_*.
    logic          dp_en = 1'b1, dp_rand = 1'b0;
    logic          dp_ready, dp_wbv;
    logic [WD-1:0] dp_wbd, dp_ctr;
    logic          man_ready = 1'b0, man_wbv = 1'b0;
    logic [WD-1:0] man_wbd = '0;

    assign tri_ready = dp_ready | man_ready;
    assign wb_valid  = dp_wbv | man_wbv;
    assign wb_data   = dp_wbv ? dp_wbd : man_wbd;

    always #5 clk = ~clk;

    pix_lift_ram dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .start     (start),
        .pass_sel  (pass_sel),
        .row_len   (row_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .tri_left  (tri_left),
        .tri_ctr   (tri_ctr),
        .tri_right (tri_right),
        .tri_addr  (tri_addr),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data)
    );

    typedef struct packed {
        logic [WD-1:0] l;
        logic [WD-1:0] c;
        logic [WD-1:0] r;
        logic [WA-1:0] a;
    } trip_t;

    trip_t         exp_q[$];
    logic [WD-1:0] mm [DEPTH];
    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Symmetric extension of an index into a row of length n.
    function automatic int refl(input int i, input int n);
        if (i < 0) return -i;
        if (i > n - 1) return 2 * (n - 1) - i;
        return i;
    endfunction

    // Reference pass: predict visits odd centres, update even ones; the
    // datapath returns centre+100, which lands back in the row.
    task automatic model_pass(input int n, input bit upd);
        trip_t t;
        for (int c = (upd ? 0 : 1); c < n; c += 2) begin
            t.l = mm[refl(c - 1, n)];
            t.c = mm[c];
            t.r = mm[refl(c + 1, n)];
            t.a = WA'(c);
            exp_q.push_back(t);
            mm[c] = mm[c] + WD'(100);
        end
    endtask

    // Monitor: compares every accepted triple and checks stability while held.
    trip_t mon_cur, mon_hold, mon_exp;
    bit    mon_hold_v = 1'b0;
    always @(negedge clk) begin
        mon_cur.l = tri_left;
        mon_cur.c = tri_ctr;
        mon_cur.r = tri_right;
        mon_cur.a = tri_addr;
        if (done) done_cnt++;
        if (!rst_n || !tri_valid) begin
            mon_hold_v = 1'b0;
        end else begin
            if (mon_hold_v) begin
                check("hold_left", mon_cur.l, mon_hold.l);
                check("hold_ctr", mon_cur.c, mon_hold.c);
                check("hold_right", mon_cur.r, mon_hold.r);
                check("hold_addr", mon_cur.a, mon_hold.a);
            end
            if (tri_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tri_unexpected: got triple at c=%0d expected none", tri_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tri_left", mon_cur.l, mon_exp.l);
                    check("tri_ctr", mon_cur.c, mon_exp.c);
                    check("tri_right", mon_cur.r, mon_exp.r);
                    check("tri_addr", mon_cur.a, mon_exp.a);
                end
                mon_hold_v = 1'b0;
            end else begin
                mon_hold = mon_cur;
                mon_hold_v = 1'b1;
            end
        end
    end

    // Lifting datapath stand-in: accepts a triple after k cycles, returns ctr+100 after d more.
    initial begin
        int k, d;
        dp_ready = 1'b0;
        dp_wbv   = 1'b0;
        dp_wbd   = '0;
        dp_ctr   = '0;
        forever begin
            @(posedge clk); #1;
            if (dp_en && tri_valid) begin
                dp_ctr = tri_ctr;
                k = dp_rand ? int'($urandom_range(0, 3)) : 0;
                d = dp_rand ? int'($urandom_range(0, 3)) : 0;
                repeat (k) begin @(posedge clk); #1; end
                dp_ready = 1'b1;
                @(posedge clk); #1;
                dp_ready = 1'b0;
                repeat (d) begin @(posedge clk); #1; end
                dp_wbv = 1'b1;
                dp_wbd = dp_ctr + WD'(100);
                @(posedge clk); #1;
                dp_wbv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic host_write(input int a, input logic [WD-1:0] dv);
        host_we   = 1'b1;
        host_addr = WA'(a);
        host_din  = dv;
        tick();
        host_we   = 1'b0;
        mm[a]     = dv;
    endtask

    task automatic host_read_check(input string name, input int a, input logic [WD-1:0] ev);
        host_addr = WA'(a);
        tick();
        check(name, host_dout, ev);
    endtask

    // Issue an accepted start; cyc counts edges from start assertion.
    task automatic run_start(input int n, input bit upd, output int cyc);
        model_pass(n, upd);
        row_len  = (WA+1)'(n);
        pass_sel = upd;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!tri_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("start_to_valid", cyc, 2);
    endtask

    task automatic wait_finish(input int cyc_in, input int d_before, output int cyc);
        cyc = cyc_in;
        while (!done && cyc < 5000) begin
            tick();
            cyc++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end
        tick();
        tick();
        check("done_once", done_cnt, d_before + 1);
        check("busy_after", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) host_read_check("mem_readback", i, mm[i]);
    endtask

    task automatic reject(input int n);
        row_len = (WA+1)'(n);
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        tick();
        check("reject_err_pulse", err, 0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, db, n;
        bit upd;
        logic [WD-1:0] old1;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tri_valid", tri_valid, 0);
        check("rst_tri_ctr", tri_ctr, 0);
        check("rst_tri_addr", tri_addr, 0);
        check("rst_host_dout", host_dout, 0);
        rst_n = 1'b1;
        tick();

        // Load x[i] = i, read back, then reset in the middle of a read
        for (int i = 0; i < 8; i++) host_write(i, WD'(i));
        host_read_check("read_addr5", 5, WD'(5));
        host_addr = WA'(3);
        #2 rst_n = 1'b0;
        #1;
        check("midread_rst_dout", host_dout, 0);
        check("midread_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        host_read_check("mem_kept_after_rst", 5, WD'(5));

        // Predict pass N=8, zero-latency datapath
        dp_rand = 1'b0;
        db = done_cnt;
        run_start(8, 1'b0, cyc);
        wait_finish(cyc, db, cyc);
        check("predict8_cycles", cyc, 13);
        readback(8);
        host_read_check("predict8_x7", 7, WD'(107));

        // Update pass on the predicted row
        db = done_cnt;
        run_start(8, 1'b1, cyc);
        wait_finish(cyc, db, cyc);
        readback(8);

        // Minimum row, both passes
        db = done_cnt;
        run_start(2, 1'b0, cyc);
        wait_finish(cyc, db, cyc);
        check("n2_predict_cycles", cyc, 4);
        db = done_cnt;
        run_start(2, 1'b1, cyc);
        wait_finish(cyc, db, cyc);
        check("n2_update_cycles", cyc, 4);
        readback(2);

        // Backpressure with stray write-back, host write and start while busy
        dp_en = 1'b0;
        old1  = mm[1];
        db    = done_cnt;
        run_start(8, 1'b0, cyc);
        man_wbv = 1'b1;
        man_wbd = WD'(999);
        tick();
        man_wbv   = 1'b0;
        host_we   = 1'b1;
        host_addr = WA'(20);
        host_din  = WD'(32'h3ff_ffff);
        tick();
        host_we = 1'b0;
        check("busy_write_err", err, 1);
        row_len  = (WA+1)'(8);
        pass_sel = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_no_err", err, 0);
        check("busy_start_busy", busy, 1);
        host_read_check("stray_wb_ignored", 1, old1);
        tick();
        check("bp_still_valid", tri_valid, 1);
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        man_wbv   = 1'b1;
        man_wbd   = old1 + WD'(100);
        tick();
        man_wbv = 1'b0;
        dp_en   = 1'b1;
        wait_finish(cyc, db, cyc);
        readback(8);
        host_read_check("busy_write_dropped", 20, mm[20]);

        // Rejected starts
        reject(7);
        reject(0);
        reject(129);

        // Reset in the middle of a pass: no done, back to idle
        dp_rand = 1'b1;
        db = done_cnt;
        run_start(16, 1'b0, cyc);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("midpass_rst_busy", busy, 0);
        check("midpass_rst_valid", tri_valid, 0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("midpass_no_done", done_cnt, db);
        check("midpass_idle_busy", busy, 0);

        // Randomized passes over random rows
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < int'(DEPTH); i++) host_write(i, WD'($urandom));
            n   = 2 * int'($urandom_range(1, DEPTH / 2));
            upd = 1'($urandom_range(0, 1));
            db  = done_cnt;
            run_start(n, upd, cyc);
            wait_finish(cyc, db, cyc);
            readback(n);
            for (int j = 0; j < 4; j++) begin
                int a;
                a = int'($urandom_range(0, DEPTH - 1));
                host_read_check("rand_read", a, mm[a]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
